// File: rtl/cmp_pkg.sv
// Shared definitions for the multi-cycle comparator: operation encodings,
// controller states and a constant-evaluable log2 helper for port widths.
package cmp_pkg;

    // Operation select encodings presented on the op port
    localparam logic [1:0] CMP_EQ  = 2'b00;
    localparam logic [1:0] CMP_NE  = 2'b01;
    localparam logic [1:0] CMP_LTS = 2'b10;
    localparam logic [1:0] CMP_LTU = 2'b11;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Ceiling log2; clog2(1) = 0, clog2(5) = 3. Usable in parameter context.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage : cmp_pkg

// File: rtl/slice_cmp.sv
// Combinational compare of one SLICE-bit chunk. When signed_top is set the
// chunk holds the sign bit, so both MSBs are flipped to turn a two's-complement
// ordering into an unsigned one before the magnitude compare.
module slice_cmp #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    input  logic             signed_top,
    output logic             eq,
    output logic             lt
);

    localparam logic [SLICE-1:0] MSB_MASK = SLICE'(1) << (SLICE - 1);

    logic [SLICE-1:0] xs;
    logic [SLICE-1:0] ys;

    // Bias the sign bit for the signed top slice, then compare as unsigned
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        xs = x;
        ys = y;
        if (signed_top) begin
            xs = x ^ MSB_MASK;
            ys = y ^ MSB_MASK;
        end
        eq = (x == y);
        lt = (xs < ys);
    end

endmodule : slice_cmp

// File: rtl/seq_compare_unit.sv
// Multi-cycle WIDTH-bit comparator for branch and set-on-less-than resolution.
// Operands are compared SLICE bits per cycle, most-significant slice first,
// with an optional early exit on the first differing slice. Requests and
// results travel over valid/ready handshakes; in_ready and out_valid are pure
// state decodes, so there is no combinational input-to-output path.
module seq_compare_unit
    import cmp_pkg::*;
#(
    parameter  int WIDTH      = 32,
    parameter  int SLICE      = 8,
    parameter  int EARLY_EXIT = 1,
    localparam int NSLICE     = WIDTH / SLICE,
    localparam int SU_W       = clog2(NSLICE + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             result,
    output logic [SU_W-1:0]  slices_used
);

    // A one-slice configuration still needs a one-bit index register.
    localparam int IDX_W = (NSLICE > 1) ? clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NSLICE - 1);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       op_q;
    logic [IDX_W-1:0] idx;
    logic             decided;
    logic             lt;

    logic [SLICE-1:0] x_slice;
    logic [SLICE-1:0] y_slice;
    logic             signed_top;
    logic             s_eq;
    logic             s_lt;

    logic             decided_nxt;
    logic             lt_nxt;
    logic             last;
    logic             res_nxt;

    // Select the slice addressed by idx from the captured operands
    always_comb begin
        x_slice = '0;
        y_slice = '0;
        for (int i = 0; i < NSLICE; i++) begin
            if (idx == IDX_W'(i)) begin
                x_slice = a_q[i*SLICE +: SLICE];
                y_slice = b_q[i*SLICE +: SLICE];
            end
        end
        signed_top = (op_q == CMP_LTS) && (idx == TOP_IDX);
    end

    slice_cmp #(
        .SLICE(SLICE)
    ) u_slice_cmp (
        .x         (x_slice),
        .y         (y_slice),
        .signed_top(signed_top),
        .eq        (s_eq),
        .lt        (s_lt)
    );

    // Fold the current slice into the running verdict and decide whether to stop
    always_comb begin
        decided_nxt = decided | ~s_eq;
        // Once a slice has differed, lower slices cannot change the ordering.
        lt_nxt      = decided ? lt : s_lt;
        last        = (idx == '0) || ((EARLY_EXIT != 0) && !s_eq);
        unique case (op_q)
            CMP_EQ:  res_nxt = ~decided_nxt;
            CMP_NE:  res_nxt = decided_nxt;
            default: res_nxt = decided_nxt & lt_nxt;
        endcase
    end

    // Controller: accept, walk slices from the top, hold the result until taken
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state       <= ST_IDLE;
            // NOTE: operand registers are reset too; they are few and this keeps idle outputs deterministic.
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= CMP_EQ;
            idx         <= '0;
            decided     <= 1'b0;
            lt          <= 1'b0;
            result      <= 1'b0;
            slices_used <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= op;
                        idx     <= TOP_IDX;
                        decided <= 1'b0;
                        lt      <= 1'b0;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    decided <= decided_nxt;
                    lt      <= lt_nxt;
                    if (last) begin
                        result      <= res_nxt;
                        slices_used <= SU_W'(NSLICE - int'(idx));
                        state       <= ST_DONE;
                    end else begin
                        idx <= idx - IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

endmodule : seq_compare_unit

// File: tb/tb_seq_compare_unit.sv
// Self-checking bench for seq_compare_unit. Two instances share the operand
// buses: dut_ee exits early, dut_cl always walks every slice. Expected results
// come from a whole-word reference model and are queued when a request is
// driven, then popped and compared when the unit presents its result.
module tb_seq_compare_unit;
    import cmp_pkg::*;

    localparam int WIDTH  = 32;
    localparam int SLICE  = 8;
    localparam int NSLICE = WIDTH / SLICE;

    typedef struct {
        logic res;
        int   slices;
        int   lat;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_ready;
    logic             sel;

    logic       in_valid0, in_ready0, out_valid0, result0;
    logic       in_valid1, in_ready1, out_valid1, result1;
    logic [2:0] su0, su1;

    logic       cur_in_ready, cur_out_valid, cur_result;
    logic [2:0] cur_su;

    exp_t sb0[$];
    exp_t sb1[$];

    int n_cmp;
    int n_bad;

    assign in_valid0 = in_valid && (sel == 1'b0);
    assign in_valid1 = in_valid && (sel == 1'b1);

    seq_compare_unit #(.WIDTH(WIDTH), .SLICE(SLICE), .EARLY_EXIT(1)) dut_ee (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .op(op), .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready),
        .result(result0), .slices_used(su0)
    );

    seq_compare_unit #(.WIDTH(WIDTH), .SLICE(SLICE), .EARLY_EXIT(0)) dut_cl (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .op(op), .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
        .result(result1), .slices_used(su1)
    );

    always_comb begin
        if (sel) begin
            cur_in_ready  = in_ready1;
            cur_out_valid = out_valid1;
            cur_result    = result1;
            cur_su        = su1;
        end else begin
            cur_in_ready  = in_ready0;
            cur_out_valid = out_valid0;
            cur_result    = result0;
            cur_su        = su0;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: whole-word comparison; latency from the highest differing bit
    function automatic exp_t model(input logic [1:0] o, input logic [WIDTH-1:0] x,
                                   input logic [WIDTH-1:0] y, input bit early);
        exp_t        e;
        logic [WIDTH-1:0] diff;
        bit          found;
        case (o)
            CMP_EQ:  e.res = (x == y);
            CMP_NE:  e.res = (x != y);
            CMP_LTS: e.res = ($signed(x) < $signed(y));
            default: e.res = (x < y);
        endcase
        diff     = x ^ y;
        e.slices = NSLICE;
        found    = 1'b0;
        if (early) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (!found && diff[i]) begin
                    found    = 1'b1;
                    e.slices = NSLICE - (i / SLICE);
                end
            end
        end
        e.lat = e.slices;
        return e;
    endfunction

    task automatic push_exp(input logic [1:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        if (sel) sb1.push_back(model(o, x, y, 1'b0));
        else     sb0.push_back(model(o, x, y, 1'b1));
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!cur_in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cur_in_ready) check("in_ready timeout", 0, 1);
    endtask

    // Wait for a result, compare against the scoreboard, optionally stall, then take it
    task automatic collect(input int hold);
        int   lat;
        exp_t e;
        logic r0;
        logic [2:0] s0;
        bit   stable;
        bit   busy;
        lat = 0;
        while (!cur_out_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!cur_out_valid) begin
            check("out_valid timeout", 0, 1);
            return;
        end
        if ((sel ? sb1.size() : sb0.size()) == 0) begin
            check("unexpected result", 1, 0);
            return;
        end
        e = sel ? sb1.pop_front() : sb0.pop_front();
        check("result", cur_result, e.res);
        check("slices_used", cur_su, e.slices);
        check("latency", lat, e.lat);
        if (hold > 0) begin
            r0     = cur_result;
            s0     = cur_su;
            stable = 1'b1;
            busy   = 1'b0;
            out_ready = 1'b0;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                if (!cur_out_valid || cur_result !== r0 || cur_su !== s0) stable = 1'b0;
                if (cur_in_ready) busy = 1'b1;
            end
            check("hold stable", stable, 1);
            check("hold in_ready low", busy, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("idle after handshake", cur_in_ready, 1);
    endtask

    task automatic run_op(input logic s, input logic [1:0] o, input logic [WIDTH-1:0] x,
                          input logic [WIDTH-1:0] y, input int hold);
        sel = s;
        wait_ready();
        in_valid = 1'b1;
        op = o;
        a  = x;
        b  = y;
        push_exp(o, x, y);
        @(posedge clk); #1;
        in_valid = 1'b0;
        collect(hold);
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        bit seen;

        n_cmp     = 0;
        n_bad     = 0;
        sel       = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = CMP_EQ;
        a         = '0;
        b         = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset state of both instances
        check("reset in_ready ee", in_ready0, 1);
        check("reset out_valid ee", out_valid0, 0);
        check("reset result ee", result0, 0);
        check("reset slices ee", su0, 0);
        check("reset in_ready cl", in_ready1, 1);
        check("reset out_valid cl", out_valid1, 0);

        // Directed cases from the test plan
        run_op(1'b0, CMP_EQ,  32'h0000_0003, 32'h0000_0003, 0);
        run_op(1'b0, CMP_NE,  32'h8000_0000, 32'h0000_0000, 0);
        run_op(1'b1, CMP_NE,  32'h8000_0000, 32'h0000_0000, 0);
        run_op(1'b0, CMP_LTS, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_op(1'b0, CMP_LTU, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_op(1'b0, CMP_LTS, 32'h0000_0003, 32'h0000_0001, 0);
        run_op(1'b0, CMP_LTU, 32'h1234_5600, 32'h1234_5601, 5);
        run_op(1'b0, CMP_LTS, 32'h8000_0001, 32'h8000_0002, 0);
        run_op(1'b1, CMP_LTS, 32'h7F00_0000, 32'h8000_00FF, 0);
        run_op(1'b1, CMP_EQ,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);

        // Randomised operands, often sharing upper bytes to vary the exit slice
        for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = ra ^ ($urandom_range(0, 255) << (8 * $urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) rb = $urandom;
            run_op(i[0], 2'($urandom_range(0, 3)), ra, rb, 0);
        end

        // Back-to-back: second request held during RUN with operands changed
        sel = 1'b0;
        wait_ready();
        in_valid = 1'b1;
        op = CMP_EQ;
        a  = 32'h1122_3344;
        b  = 32'h1122_3344;
        push_exp(CMP_EQ, 32'h1122_3344, 32'h1122_3344);
        @(posedge clk); #1;
        op = CMP_NE;
        a  = 32'hAA00_0000;
        b  = 32'h0000_0000;
        push_exp(CMP_NE, 32'hAA00_0000, 32'h0000_0000);
        check("b2b in_ready busy", cur_in_ready, 0);
        collect(0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b second accepted", cur_in_ready, 0);
        collect(0);
        check("b2b queue drained", sb0.size(), 0);

        // Reset pulse during RUN aborts the operation
        sel = 1'b0;
        wait_ready();
        in_valid = 1'b1;
        op = CMP_EQ;
        a  = 32'h0000_0077;
        b  = 32'h0000_0077;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid0) seen = 1'b1;
        end
        check("reset abort out_valid", seen, 0);
        check("reset abort in_ready", in_ready0, 1);
        run_op(1'b0, CMP_EQ, 32'h0000_0005, 32'h0000_0005, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_seq_compare_unit

// File: doc/seq_compare_unit.md
# seq_compare_unit

Parametrised multi-cycle comparator for the MIPS datapath. It is the successor to the single-cycle 32-bit equality block and sits beside the ALU for branch and set-on-less-than resolution. Two WIDTH-bit operands are compared in SLICE-bit chunks, most-significant slice first. It supports equal, not-equal, signed less-than and unsigned less-than, with optional early exit on the first differing slice. Operands are accepted, and results returned, over valid/ready handshakes.

## Interface
- WIDTH, 32: operand width; must be a multiple of SLICE.
- SLICE, 8: bits compared per cycle; NSLICE = WIDTH/SLICE, minimum 1.
- EARLY_EXIT, 1: 1 = finish on first differing slice; 0 = always examine all NSLICE slices (constant latency).
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  unit can accept a request (high only in IDLE).
- op  input  2  operation: 00 EQ, 01 NE, 10 LTS (signed a<b), 11 LTU (unsigned a<b).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- result  output  1  comparison outcome.
- slices_used  output  clog2(NSLICE+1)  number of slices examined for this result.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at an edge: capture a, b and op; set idx=NSLICE-1; clear the decided flag; go to RUN.
- RUN:
  - Each cycle, compare slice idx of A and B.
  - For LTS on the top slice, invert the MSB of both slices before the magnitude compare; all other slices compare unsigned.
  - First differing slice:
    - Set the decided flag and latch lt = (a_slice < b_slice).
    - With EARLY_EXIT=1, go to DONE immediately.
    - Later slices never overwrite a decided lt.
  - Slices equal and idx==0, or idx==0 with EARLY_EXIT=0: go to DONE.
  - Otherwise decrement idx.
- Result encoding:
  - EQ = !decided.
  - NE = decided.
  - LTS/LTU = decided & lt.
- DONE:
  - out_valid=1; result and slices_used are held stable until out_ready.
  - On out_valid & out_ready, return to IDLE.
- in_valid is ignored outside IDLE. The captured operands are immune to input changes after acceptance.
- Reset values: state IDLE, out_valid 0, result 0, slices_used 0, idx 0, decided 0, in_ready 1 once reset is released.
- Reset asserted mid-operation: the operation is aborted, no out_valid is produced, and the unit is in IDLE on release.

## Timing
- Accept edge E0; RUN evaluates one slice per edge E1..Ek; out_valid is high from edge Ek.
- k = index of the first differing slice counted from the MSB (1..NSLICE), or NSLICE if the operands are equal.
- k = NSLICE always when EARLY_EXIT=0.
- Minimum handshake-to-handshake period: k+2 cycles (accept, k RUN cycles, DONE with out_ready high). A new request can be accepted on the edge after the output handshake.
- out_ready held low: DONE persists indefinitely and outputs do not change.
- NSLICE=1: one RUN cycle, which behaves as a registered single-cycle compare.
- result and slices_used are registered; in_ready and out_valid are decoded from state with no combinational input-to-output path.

## Structure
- Package cmp_pkg:
  - op encoding constants CMP_EQ, CMP_NE, CMP_LTS, CMP_LTU.
  - FSM state enum.
  - Helper function clog2.
- Sub-module slice_cmp, combinational:
  - Inputs: SLICE-bit x and y, and a signed_top flag.
  - Outputs: eq and lt.
  - Instantiated once; slice selection is by an idx-driven mux.

## Test plan
- EQ, WIDTH=32, SLICE=8, EARLY_EXIT=1, a=b=0x00000003 -> result=1, slices_used=4, out_valid 4 cycles after accept.
- NE, a=0x80000000, b=0x00000000 -> result=1, slices_used=1; same with EARLY_EXIT=0 -> result=1, slices_used=4.
- LTS, a=0xFFFFFFFF (-1), b=0x00000001 -> result=1; LTU with the same operands -> result=0; LTS, a=0x00000003, b=0x00000001 -> result=0.
- LTU, a=0x12345600, b=0x12345601 -> result=1, slices_used=4; with out_ready held low 5 cycles, the result stays stable and in_ready stays 0.
- Back-to-back: a second in_valid asserted during RUN is ignored until IDLE, then accepted; two results come out in order.
- rst_n pulsed low during RUN -> out_valid never rises, in_ready=1 after release, and the next EQ 0x5/0x5 returns 1.
